// File: rtl/adbg_or1k_spr_arbiter_if.sv
// Bundle of the requester-side and SPR-side signals of the OR1K SPR arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the CPU SPR port.
interface adbg_or1k_spr_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_stb_i;
  logic [NREQ-1:0]    req_we_i;
  logic [32*NREQ-1:0] req_addr_i;
  logic [32*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]    req_ack_o;
  logic [NREQ-1:0]    req_err_o;
  logic [31:0]        req_data_o;
  logic [NREQ-1:0]    grant_o;
  logic [31:0]        spr_addr_o;
  logic [31:0]        spr_data_o;
  logic               spr_we_o;
  logic               spr_stb_o;
  logic [31:0]        spr_data_i;
  logic               spr_ack_i;

  modport slave (
    input  req_stb_i, req_we_i, req_addr_i, req_data_i, spr_data_i, spr_ack_i,
    output req_ack_o, req_err_o, req_data_o, grant_o,
           spr_addr_o, spr_data_o, spr_we_o, spr_stb_o
  );

  modport master (
    output req_stb_i, req_we_i, req_addr_i, req_data_i, spr_data_i, spr_ack_i,
    input  req_ack_o, req_err_o, req_data_o, grant_o,
           spr_addr_o, spr_data_o, spr_we_o, spr_stb_o
  );
endinterface

// File: rtl/adbg_or1k_spr_arbiter.sv
// Round-robin arbiter sharing one OR1K SPR port among NREQ debug requesters,
// one transfer at a time, with a watchdog that completes a stuck access with an error.
module adbg_or1k_spr_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic                    cpu_clk_i,
  input  logic                    rst_i,
  adbg_or1k_spr_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [CW-1:0]   cnt;
  logic            err;
  logic [NREQ-1:0] grant;
  logic [31:0]     spr_addr;
  logic [31:0]     spr_wdata;
  logic            spr_we;
  logic [31:0]     rdata;

  // First pending requester after ptr, wrapping; the nearest offset is evaluated last so it wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] stb,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (stb[(int'(last) + k) % NREQ]) pick = IW'((int'(last) + k) % NREQ);
    end
    return pick;
  endfunction

  assign win = rr_pick(bus.req_stb_i, ptr);

  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
      err       <= 1'b0;
      grant     <= '0;
      spr_addr  <= '0;
      spr_wdata <= '0;
      spr_we    <= 1'b0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req_stb_i) begin
            grant     <= NREQ'(1) << win;
            ptr       <= win;
            spr_addr  <= bus.req_addr_i[win*32 +: 32];
            spr_wdata <= bus.req_data_i[win*32 +: 32];
            spr_we    <= bus.req_we_i[win];
            cnt       <= '0;
            err       <= 1'b0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A late ack on the timeout cycle still counts as a normal completion.
          if (bus.spr_ack_i) begin
            rdata <= spr_we ? 32'h0 : bus.spr_data_i;
            state <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            rdata <= 32'h0;
            err   <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          grant <= '0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.spr_stb_o  = (state == ST_ACCESS);
  assign bus.req_ack_o  = (state == ST_RESP) ? grant : '0;
  assign bus.req_err_o  = (state == ST_RESP && err) ? grant : '0;
  assign bus.grant_o    = grant;
  assign bus.req_data_o = rdata;
  assign bus.spr_addr_o = spr_addr;
  assign bus.spr_data_o = spr_wdata;
  assign bus.spr_we_o   = spr_we;
endmodule

// File: tb/tb_adbg_or1k_spr_arbiter.sv
// Directed bench for adbg_or1k_spr_arbiter: a cycle table for reads, writes and
// contention, plus hand-written timeout, ack-at-timeout and mid-transfer reset sequences.
module tb_adbg_or1k_spr_arbiter;
  localparam logic [31:0] A0 = 32'h0000_2810;
  localparam logic [31:0] A1 = 32'h0000_3001;
  localparam logic [31:0] D0 = 32'h0BAD_F00D;
  localparam logic [31:0] D1 = 32'h1234_5678;

  logic cpu_clk_i = 1'b0;
  logic rst_i     = 1'b1;
  int   total     = 0;
  int   bad       = 0;

  adbg_or1k_spr_arbiter_if #(.NREQ(2)) bus ();

  adbg_or1k_spr_arbiter #(.NREQ(2), .TIMEOUT(15), .CW(8)) dut (
    .cpu_clk_i (cpu_clk_i),
    .rst_i     (rst_i),
    .bus       (bus)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  typedef struct {
    logic [1:0]  stb;
    logic [1:0]  we;
    logic        ack;
    logic [31:0] sdata;
    logic        xstb;
    logic [1:0]  xgnt;
    logic [1:0]  xack;
    logic [1:0]  xerr;
    logic [31:0] xrdata;
    logic [31:0] xaddr;
    logic        xwe;
    logic [31:0] xwdata;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_stb;
    bit  got;

    // T1 read (rows 0-4), T2 zero-wait write (5-7), T3 contention (8-19)
    tbl[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[1]  = '{2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[2]  = '{2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[3]  = '{2'b01, 2'b00, 1'b1, 32'hCAFE_0001, 1'b0, 2'b01, 2'b01, 2'b00, 32'hCAFE_0001, A0, 1'b0, D0};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[5]  = '{2'b10, 2'b10, 1'b0, 32'h0,         1'b1, 2'b10, 2'b00, 2'b00, 32'h0,         A1, 1'b1, D1};
    tbl[6]  = '{2'b10, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b10, 2'b10, 2'b00, 32'h0,         A1, 1'b1, D1};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A1, 1'b1, D1};
    tbl[8]  = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 32'h0000_0011, 1'b0, 2'b01, 2'b01, 2'b00, 32'h0000_0011, A0, 1'b0, D0};
    tbl[10] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[11] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b1, 2'b10, 2'b00, 2'b00, 32'h0,         A1, 1'b0, D1};
    tbl[12] = '{2'b11, 2'b00, 1'b1, 32'h0000_0022, 1'b0, 2'b10, 2'b10, 2'b00, 32'h0000_0022, A1, 1'b0, D1};
    tbl[13] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A1, 1'b0, D1};
    tbl[14] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[15] = '{2'b11, 2'b00, 1'b1, 32'h0000_0033, 1'b0, 2'b01, 2'b01, 2'b00, 32'h0000_0033, A0, 1'b0, D0};
    tbl[16] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A0, 1'b0, D0};
    tbl[17] = '{2'b11, 2'b00, 1'b1, 32'h0,         1'b1, 2'b10, 2'b00, 2'b00, 32'h0,         A1, 1'b0, D1};
    tbl[18] = '{2'b11, 2'b00, 1'b1, 32'h0000_0044, 1'b0, 2'b10, 2'b10, 2'b00, 32'h0000_0044, A1, 1'b0, D1};
    tbl[19] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         A1, 1'b0, D1};

    bus.req_stb_i  = '0;
    bus.req_we_i   = '0;
    bus.req_addr_i = {A1, A0};
    bus.req_data_i = {D1, D0};
    bus.spr_data_i = '0;
    bus.spr_ack_i  = 1'b0;

    #12;
    check("rst_stb",   32'(bus.spr_stb_o),  32'h0);
    check("rst_grant", 32'(bus.grant_o),    32'h0);
    check("rst_ack",   32'(bus.req_ack_o),  32'h0);
    check("rst_err",   32'(bus.req_err_o),  32'h0);
    check("rst_rdata", bus.req_data_o,      32'h0);
    check("rst_addr",  bus.spr_addr_o,      32'h0);
    check("rst_wdata", bus.spr_data_o,      32'h0);
    check("rst_we",    32'(bus.spr_we_o),   32'h0);
    @(negedge cpu_clk_i);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      bus.req_stb_i  = tbl[i].stb;
      bus.req_we_i   = tbl[i].we;
      bus.spr_ack_i  = tbl[i].ack;
      bus.spr_data_i = tbl[i].sdata;
      tick();
      check($sformatf("row%0d_stb", i),   32'(bus.spr_stb_o), 32'(tbl[i].xstb));
      check($sformatf("row%0d_grant", i), 32'(bus.grant_o),   32'(tbl[i].xgnt));
      check($sformatf("row%0d_ack", i),   32'(bus.req_ack_o), 32'(tbl[i].xack));
      check($sformatf("row%0d_err", i),   32'(bus.req_err_o), 32'(tbl[i].xerr));
      if (tbl[i].xack != 2'b00)
        check($sformatf("row%0d_rdata", i), bus.req_data_o, tbl[i].xrdata);
      if (tbl[i].xstb) begin
        check($sformatf("row%0d_addr", i),  bus.spr_addr_o,       tbl[i].xaddr);
        check($sformatf("row%0d_we", i),    32'(bus.spr_we_o),    32'(tbl[i].xwe));
        check($sformatf("row%0d_wdata", i), bus.spr_data_o,       tbl[i].xwdata);
      end
    end

    // T4: no ack ever; the watchdog must end the access after 16 strobe cycles
    bus.req_stb_i = 2'b01;
    bus.req_we_i  = 2'b00;
    bus.spr_ack_i = 1'b0;
    n_stb = 0;
    got   = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (c == 0) check("t4_grant", 32'(bus.grant_o), 32'h1);
      if (bus.spr_stb_o) n_stb++;
      if (bus.req_ack_o != 2'b00) begin
        got = 1'b1;
        check("t4_ack",   32'(bus.req_ack_o), 32'h1);
        check("t4_err",   32'(bus.req_err_o), 32'h1);
        check("t4_rdata", bus.req_data_o,     32'h0);
      end
    end
    check("t4_done",       32'(got), 32'h1);
    check("t4_stb_cycles", n_stb,    16);
    bus.req_stb_i = 2'b00;
    tick();
    check("t4_idle_grant", 32'(bus.grant_o),   32'h0);
    check("t4_idle_err",   32'(bus.req_err_o), 32'h0);

    // T5: ack arrives on the 16th strobe cycle, same edge the watchdog would fire
    bus.req_stb_i = 2'b10;
    tick();
    check("t5_grant", 32'(bus.grant_o), 32'h2);
    for (int c = 0; c < 15; c++) tick();
    check("t5_stb16", 32'(bus.spr_stb_o), 32'h1);
    bus.spr_ack_i  = 1'b1;
    bus.spr_data_i = 32'hA5A5_A5A5;
    tick();
    check("t5_ack",   32'(bus.req_ack_o), 32'h2);
    check("t5_err",   32'(bus.req_err_o), 32'h0);
    check("t5_rdata", bus.req_data_o,     32'hA5A5_A5A5);
    bus.req_stb_i = 2'b00;
    bus.spr_ack_i = 1'b0;
    tick();

    // T6: reset in the middle of an access, then check the pointer restarts at req0
    bus.req_stb_i = 2'b01;
    tick();
    check("t6_grant", 32'(bus.grant_o), 32'h1);
    tick();
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_stb",   32'(bus.spr_stb_o), 32'h0);
    check("t6_rst_grant", 32'(bus.grant_o),   32'h0);
    check("t6_rst_ack",   32'(bus.req_ack_o), 32'h0);
    @(negedge cpu_clk_i);
    bus.req_stb_i = 2'b00;
    @(negedge cpu_clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t6_noack%0d", c), 32'(bus.req_ack_o), 32'h0);
    end
    bus.req_stb_i = 2'b11;
    tick();
    check("t6_regrant", 32'(bus.grant_o),   32'h1);
    check("t6_restb",   32'(bus.spr_stb_o), 32'h1);
    bus.req_stb_i = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
